// File: rtl/adc_sample_ctrl.sv
// Periodic ADC sampling controller: fires an SPI conversion every PERIOD cycles
// and averages 2^AVG_LOG2 results into one 12-bit sample.
// Ports: clk/rst (async active-low), run/clr control, spi_ss/spi_data from the
// SPI receiver, spi_en start pulse, sample/sample_valid result, busy/err/ovr status.
module adc_sample_ctrl #(
  parameter int PERIOD   = 1000,
  parameter int AVG_LOG2 = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        clr,
  input  logic        spi_ss,
  input  logic [15:0] spi_data,
  output logic        spi_en,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        busy,
  output logic        err,
  output logic        ovr
);

  localparam int CW = $clog2(PERIOD);
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int AW = 12 + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;

  typedef enum logic [2:0] {
    IDLE, START, WAIT_LOW, WAIT_HIGH, SETTLE, ACC
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   period_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            settle_cnt;
  logic [AW-1:0]   acc;
  logic [NW-1:0]   num;
  logic            tick;
  logic            timeout_evt;
  logic            ovr_evt;
  logic            en_nxt;
  logic [AW-1:0]   acc_sum;
  logic [AW-1:0]   acc_mean;
  logic            unused_hi;

  // The receiver frame register carries status in the upper nibble; only the
  // 12-bit conversion result is used.
  assign unused_hi = ^spi_data[15:12];

  assign tick     = run && (period_cnt == CW'(PERIOD - 1));
  assign acc_sum  = acc + AW'(spi_data[11:0]);
  assign acc_mean = acc_sum >> AVG_LOG2;

  // Period counter: free-runs only while sampling is enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               period_cnt <= '0;
    else if (!run)                          period_cnt <= '0;
    else if (period_cnt == CW'(PERIOD - 1)) period_cnt <= '0;
    else                                    period_cnt <= period_cnt + 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (tick) next_state = START;
      START:     next_state = WAIT_LOW;
      WAIT_LOW: begin
        if (!spi_ss)                         next_state = WAIT_HIGH;
        else if (tmo_cnt == TW'(TIMEOUT))    next_state = IDLE;
      end
      WAIT_HIGH: if (spi_ss) next_state = SETTLE;
      SETTLE:    if (settle_cnt) next_state = ACC;
      ACC:       next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // FSM outputs and events
  always_comb begin
    busy        = (state != IDLE);
    en_nxt      = (next_state == START);
    timeout_evt = (state == WAIT_LOW) && spi_ss && (tmo_cnt == TW'(TIMEOUT));
    ovr_evt     = tick && (state != IDLE);
  end

  // Timeout and settle counters. The settle counter gives SETTLE two cycles
  // so the receiver's output register has updated before ACC reads it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt    <= '0;
      settle_cnt <= 1'b0;
    end else begin
      if (state == START)
        tmo_cnt <= '0;
      else if (state == WAIT_LOW && spi_ss && tmo_cnt != TW'(TIMEOUT))
        tmo_cnt <= tmo_cnt + 1'b1;
      settle_cnt <= (state == SETTLE) ? ~settle_cnt : 1'b0;
    end
  end

  // Accumulator and registered result outputs. With run low the partial
  // average is discarded so a restart always begins from a fresh set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc          <= '0;
      num          <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      spi_en       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      spi_en       <= en_nxt;
      if (!run) begin
        acc <= '0;
        num <= '0;
      end else if (state == ACC) begin
        if (num == NW'((1 << AVG_LOG2) - 1)) begin
          sample       <= acc_mean[11:0];
          sample_valid <= 1'b1;
          acc          <= '0;
          num          <= '0;
        end else begin
          acc <= acc_sum;
          num <= num + 1'b1;
        end
      end
    end
  end

  // Sticky flags: a new event in the same cycle as clr keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
      ovr <= 1'b0;
    end else begin
      if (timeout_evt) err <= 1'b1;
      else if (clr)    err <= 1'b0;
      if (ovr_evt)     ovr <= 1'b1;
      else if (clr)    ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_sample_ctrl.sv
module tb_adc_sample_ctrl;
  localparam int P = 64;
  localparam int A = 2;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        clr = 1'b0;
  logic        spi_ss = 1'b1;
  logic [15:0] spi_data = 16'h0;
  logic        spi_en;
  logic [11:0] sample;
  logic        sample_valid;
  logic        busy;
  logic        err;
  logic        ovr;

  adc_sample_ctrl #(.PERIOD(P), .AVG_LOG2(A), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .run(run), .clr(clr), .spi_ss(spi_ss),
    .spi_data(spi_data), .spi_en(spi_en), .sample(sample),
    .sample_valid(sample_valid), .busy(busy), .err(err), .ovr(ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: accepted conversions of the current set, expected
  // averages with the cycle of the final frame's ss rise, spi_en times.
  int          gen = 0;
  int          part[$];
  int          exp_val[$];
  int          exp_rise[$];
  int          en_times[$];
  logic [15:0] data_q[$];
  bit          stuck = 1'b0;
  int          long_low = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // SPI receiver model: answers each spi_en with one frame of random timing.
  task automatic frame();
    int g = gen;
    int lead = int'($urandom_range(1, 8));
    int low = (long_low > 0) ? long_low : int'($urandom_range(4, 20));
    int sum;
    logic [15:0] d;
    long_low = 0;
    d = (data_q.size() > 0) ? data_q.pop_front() : 16'($urandom);
    repeat (lead) @(posedge clk);
    #1 spi_ss = 1'b0;
    repeat (low) @(posedge clk);
    #1 spi_data = d;
    spi_ss = 1'b1;
    if (g == gen && run) begin
      part.push_back(int'(d[11:0]));
      if (part.size() == (1 << A)) begin
        sum = 0;
        foreach (part[i]) sum += part[i];
        exp_val.push_back(sum >> A);
        exp_rise.push_back(cyc);
        part.delete();
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (spi_en === 1'b1 && !stuck) frame();
    end
  end

  // Monitor: records start pulses and checks every result against the model.
  always @(negedge clk) begin
    if (spi_en === 1'b1) en_times.push_back(cyc);
    if (sample_valid === 1'b1) begin
      if (exp_val.size() == 0) begin
        chk("unexpected_sample", {20'h0, sample}, 32'hFFFFFFFF);
      end else begin
        int ev, er;
        ev = exp_val.pop_front();
        er = exp_rise.pop_front();
        chk("sample", {20'h0, sample}, ev);
        chk("sample_latency", cyc - er, 4);
      end
    end
  end

  task automatic wait_en(input int n);
    for (int k = 0; k < 4000 && en_times.size() < n; k++) @(posedge clk);
    if (en_times.size() < n) chk("spi_en_timeout", en_times.size(), n);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    if (k == 400) chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_ss_low();
    int k;
    for (k = 0; k < 400 && spi_ss !== 1'b0; k++) @(posedge clk);
    if (k == 400) chk("ss_low_timeout", spi_ss, 0);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_spi_en"}, spi_en, 0);
    chk({tag, "_sample"}, sample, 0);
    chk({tag, "_sample_valid"}, sample_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_ovr"}, ovr, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, n, s, k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Known set: mean of 0x100..0x400 is 0x280, starts one period apart.
    data_q = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    @(posedge clk); #1 run = 1'b1;
    c = cyc;
    wait_en(1);
    chk("first_spi_en_cycle", en_times[0], c + P);
    wait_en(4);
    wait_idle();
    for (int i = 1; i < 4; i++) chk("spi_en_spacing", en_times[i] - en_times[i-1], P);

    // Upper nibble must be ignored.
    data_q = '{16'hFABC, 16'hFABC, 16'hFABC, 16'hFABC};
    wait_en(8);
    wait_idle();

    // Random data and frame timing.
    wait_en(8 + 20);
    wait_idle();

    // Timeout: ss never drops after spi_en.
    stuck = 1'b1;
    n = en_times.size();
    wait_en(n + 1);
    s = en_times[n];
    while (cyc < s + T) @(negedge clk);
    chk("err_before_timeout", err, 0);
    while (cyc < s + T + 2) @(negedge clk);
    chk("err_after_timeout", err, 1);
    chk("busy_after_timeout", busy, 0);
    stuck = 1'b0;
    pulse_clr();
    chk("err_cleared", err, 0);

    // Frame longer than the period: next tick dropped, ovr set, sampling resumes.
    chk("ovr_before", ovr, 0);
    n = en_times.size();
    long_low = 80;
    wait_en(n + 2);
    chk("ovr_spacing", en_times[n+1] - en_times[n], 2 * P);
    chk("ovr_set", ovr, 1);
    pulse_clr();
    chk("ovr_cleared", ovr, 0);
    wait_idle();

    // Drop run mid-frame after two samples of a set, then restart fresh.
    for (k = 0; k < 2000 && part.size() != 2; k++) @(posedge clk);
    if (k == 2000) chk("part_timeout", part.size(), 2);
    n = en_times.size();
    wait_en(n + 1);
    wait_ss_low();
    @(posedge clk); #1 run = 1'b0;
    gen++;
    part.delete();
    wait_idle();
    repeat (3) @(posedge clk);
    data_q = '{16'h0010, 16'h0020, 16'h0030, 16'h0041};
    @(posedge clk); #1 run = 1'b1;
    n = en_times.size();
    wait_en(n + 4);
    wait_idle();

    // Reset while waiting for ss to rise.
    n = en_times.size();
    wait_en(n + 1);
    wait_ss_low();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    gen++;
    part.delete();
    #1 chk_all_zero("midframe_reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    data_q = '{16'h0FFF, 16'h0001, 16'h0800, 16'h07FF};
    n = en_times.size();
    wait_en(n + 4);
    wait_idle();

    repeat (10) @(posedge clk);
    chk("pending_expected", exp_val.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
